muldiv: RTL

Multi-cycle integer multiply/divide unit beside the single-cycle `alu` in the execute stage. It takes the same two operand buses (`DATA_IN1`=rs, `DATA_IN2`=rt), runs MULT/MULTU/DIV/DIVU iteratively, and holds results in architectural HI/LO registers for MFHI/MFLO. The pipeline stalls on `BUSY`, which gives the ALU-side datapath a result end that completes over many cycles.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and small op-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  function automatic logic is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on the 2*WIDTH+1-bit accumulator.
// Divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] mul_next;

  // Shift-add: upper half plus multiplicand, then shift the whole accumulator right.
  assign sum      = acc[2*WIDTH:WIDTH] + {1'b0, operand};
  assign mul_next = {1'b0, (acc[0] ? sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [2*WIDTH:0] div_next;

  // Restoring divide: upper WIDTH+1 bits are the partial remainder.
  assign shifted  = {acc[2*WIDTH-1:0], 1'b0};
  assign fits     = shifted[2*WIDTH:WIDTH] >= {1'b0, operand};
  assign trial    = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
  assign div_next = fits ? {trial, shifted[WIDTH-1:1], 1'b1} : shifted;
  assign acc_next = div_mode ? div_next : mul_next;
`else
  assign acc_next = div_mode ? acc : mul_next;
`endif

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional divider datapath enabled by defining MULDIV_DIV_EN.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] DATA_IN1,
  input  logic [WIDTH-1:0] DATA_IN2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e           state_reg, state_next;
  md_op_e              op_reg, req_op;
  logic [WIDTH-1:0]    a_reg, b_reg, mag_reg, hi_reg, lo_reg;
  logic [AW-1:0]       acc_reg, acc_next;
  logic [CW-1:0]       cnt_reg;
  logic                neg_res_reg, done_reg;
  logic                div_op, sgn_op, skip_calc;
  logic [WIDTH-1:0]    abs_a, abs_b;
  logic [2*WIDTH-1:0]  prod;

  assign req_op = md_op_e'(MDOp);
  assign div_op = is_div(op_reg);
  assign sgn_op = is_signed_op(op_reg);
  assign abs_a  = (sgn_op && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign abs_b  = (sgn_op && b_reg[WIDTH-1]) ? -b_reg : b_reg;
  assign prod   = neg_res_reg ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];

`ifdef MULDIV_DIV_EN
  logic             neg_rem_reg;
  logic [WIDTH-1:0] quo, rem;
  assign quo       = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem       = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  assign skip_calc = div_op && (b_reg == '0);
`else
  assign skip_calc = div_op;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .operand  (mag_reg),
    .div_mode (div_op),
    .acc_next (acc_next)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (START && (is_mul(req_op) || is_div(req_op))) state_next = ST_PREP;
      ST_PREP: state_next = skip_calc ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt_reg == LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_reg != ST_IDLE);
    DONE = done_reg;
  end

  assign HI = hi_reg;
  assign LO = lo_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      op_reg      <= MD_NOP;
      a_reg       <= '0;
      b_reg       <= '0;
      mag_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      neg_res_reg <= 1'b0;
      done_reg    <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_reg <= 1'b0;
`endif
    end else begin
      done_reg <= (state_reg == ST_FIX);
      case (state_reg)
        ST_IDLE: if (START) begin
          case (req_op)
            MD_MTHI: hi_reg <= DATA_IN1;
            MD_MTLO: lo_reg <= DATA_IN1;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              op_reg <= req_op;
              a_reg  <= DATA_IN1;
              b_reg  <= DATA_IN2;
            end
            default: ;
          endcase
        end
        ST_PREP: begin
          neg_res_reg <= sgn_op && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
`ifdef MULDIV_DIV_EN
          neg_rem_reg <= sgn_op && a_reg[WIDTH-1];
`endif
          cnt_reg <= '0;
          // Dividend (or multiplier) sits in the low half; the other magnitude is the step operand.
          acc_reg <= {{(WIDTH+1){1'b0}}, (div_op ? abs_a : abs_b)};
          mag_reg <= div_op ? abs_b : abs_a;
        end
        ST_CALC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_FIX: begin
          if (!div_op) begin
            hi_reg <= prod[2*WIDTH-1:WIDTH];
            lo_reg <= prod[WIDTH-1:0];
          end
`ifdef MULDIV_DIV_EN
          else if (b_reg == '0) begin
            hi_reg <= a_reg;
            lo_reg <= '1;
          end else begin
            hi_reg <= rem;
            lo_reg <= quo;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
